// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: three-master request/grant arbiter for the shared SoC
// memory bus. Port 0 (debug) has priority over ports 1/2, which alternate
// round-robin and are protected from starvation by saturating wait counters.
// Grants are combinational; read data returns one cycle after the grant.
module mem_bus_arbiter #(
  parameter int ADR_W    = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lock,
  input  logic                req0,
  input  logic                req1,
  input  logic                req2,
  input  logic [ADR_W-1:0]    adr0,
  input  logic [ADR_W-1:0]    adr1,
  input  logic [ADR_W-1:0]    adr2,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W-1:0]   wdata2,
  input  logic [DATA_W/8-1:0] wren0,
  input  logic [DATA_W/8-1:0] wren1,
  input  logic [DATA_W/8-1:0] wren2,
  output logic                gnt0,
  output logic                gnt1,
  output logic                gnt2,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic                rvalid2,
  output logic [DATA_W-1:0]   rdata,
  output logic                bus_op,
  output logic [ADR_W-1:0]    bus_adr,
  output logic [DATA_W-1:0]   bus_di,
  output logic [DATA_W/8-1:0] bus_wren,
  input  logic [DATA_W-1:0]   bus_do
);

  localparam logic [7:0] MAXW = 8'(MAX_WAIT);

  // Round-robin preference between ports 1 and 2.
  typedef enum logic {RR_P1 = 1'b0, RR_P2 = 1'b1} rr_t;

  rr_t        rr_ptr;
  logic [7:0] wait1;
  logic [7:0] wait2;
  logic [2:0] gnt;
  logic [2:0] pend;
  logic       starve1;
  logic       starve2;

  assign starve1 = req1 && (wait1 == MAXW);
  assign starve2 = req2 && (wait2 == MAXW);

  // Priority selection: lock, starved ports, port 0, then round-robin.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (lock) begin
        gnt[0] = req0;
      end else if (starve1 && starve2) begin
        if (rr_ptr == RR_P2) gnt[2] = 1'b1;
        else                 gnt[1] = 1'b1;
      end else if (starve1) begin
        gnt[1] = 1'b1;
      end else if (starve2) begin
        gnt[2] = 1'b1;
      end else if (req0) begin
        gnt[0] = 1'b1;
      end else if (req1 && req2) begin
        if (rr_ptr == RR_P2) gnt[2] = 1'b1;
        else                 gnt[1] = 1'b1;
      end else if (req1) begin
        gnt[1] = 1'b1;
      end else if (req2) begin
        gnt[2] = 1'b1;
      end
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign gnt2 = gnt[2];

  // Bus drive: winner's fields, all-zero when idle for the OR-combined bus.
  always_comb begin
    bus_op   = |gnt;
    bus_adr  = '0;
    bus_di   = '0;
    bus_wren = '0;
    if (gnt[0]) begin
      bus_adr = adr0; bus_di = wdata0; bus_wren = wren0;
    end else if (gnt[1]) begin
      bus_adr = adr1; bus_di = wdata1; bus_wren = wren1;
    end else if (gnt[2]) begin
      bus_adr = adr2; bus_di = wdata2; bus_wren = wren2;
    end
  end

  // Arbitration state and pending read responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= RR_P1;
      wait1  <= '0;
      wait2  <= '0;
      pend   <= '0;
    end else begin
      pend <= gnt & {(wren2 == '0), (wren1 == '0), (wren0 == '0)};
      if (gnt[1])      rr_ptr <= RR_P2;
      else if (gnt[2]) rr_ptr <= RR_P1;
      if (gnt[1] || !req1)          wait1 <= '0;
      else if (!lock && wait1 < MAXW) wait1 <= wait1 + 8'd1;
      if (gnt[2] || !req2)          wait2 <= '0;
      else if (!lock && wait2 < MAXW) wait2 <= wait2 + 8'd1;
    end
  end

  assign rvalid0 = pend[0];
  assign rvalid1 = pend[1];
  assign rvalid2 = pend[2];
  assign rdata   = (|pend) ? bus_do : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two instances (MAX_WAIT 15 and 3)
// share the same stimulus; each scenario checks the relevant instance.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset, lock, req0, req1, req2;
  logic [31:0] adr0, adr1, adr2, wdata0, wdata1, wdata2, bus_do;
  logic [3:0]  wren0, wren1, wren2;

  logic        a_g0, a_g1, a_g2, a_v0, a_v1, a_v2, a_op;
  logic [31:0] a_rdata, a_adr, a_di;
  logic [3:0]  a_wren;
  logic        b_g0, b_g1, b_g2, b_v0, b_v1, b_v2, b_op;
  logic [31:0] b_rdata, b_adr, b_di;
  logic [3:0]  b_wren;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut_a (
    .clk(clk), .reset(reset), .lock(lock),
    .req0(req0), .req1(req1), .req2(req2),
    .adr0(adr0), .adr1(adr1), .adr2(adr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .wren0(wren0), .wren1(wren1), .wren2(wren2),
    .gnt0(a_g0), .gnt1(a_g1), .gnt2(a_g2),
    .rvalid0(a_v0), .rvalid1(a_v1), .rvalid2(a_v2),
    .rdata(a_rdata), .bus_op(a_op), .bus_adr(a_adr), .bus_di(a_di),
    .bus_wren(a_wren), .bus_do(bus_do)
  );

  mem_bus_arbiter #(.ADR_W(32), .DATA_W(32), .MAX_WAIT(3)) dut_b (
    .clk(clk), .reset(reset), .lock(lock),
    .req0(req0), .req1(req1), .req2(req2),
    .adr0(adr0), .adr1(adr1), .adr2(adr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .wren0(wren0), .wren1(wren1), .wren2(wren2),
    .gnt0(b_g0), .gnt1(b_g1), .gnt2(b_g2),
    .rvalid0(b_v0), .rvalid1(b_v1), .rvalid2(b_v2),
    .rdata(b_rdata), .bus_op(b_op), .bus_adr(b_adr), .bus_di(b_di),
    .bus_wren(b_wren), .bus_do(bus_do)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    {req0, req1, req2, lock} = '0;
    cyc();
    reset = 1'b0;
  endtask

  logic [2:0] exp_pr [8];
  logic [2:0] exp_st [8];

  initial begin
    exp_pr = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
    exp_st = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010};

    reset = 1'b1; lock = 1'b0;
    req0 = 1'b0; req1 = 1'b1; req2 = 1'b0;
    adr0 = 32'h0000_0100; adr1 = 32'h0000_0010; adr2 = 32'h0002_0020;
    wdata0 = 32'hA0A0_A0A0; wdata1 = 32'hB1B1_B1B1; wdata2 = 32'hC2C2_C2C2;
    wren0 = 4'h0; wren1 = 4'h0; wren2 = 4'h0;
    bus_do = 32'hDEAD_BEEF;

    // Reset state: grants forced low even with req1 asserted.
    @(negedge clk);
    chk("rst_gnt", {a_g2, a_g1, a_g0}, 3'b000);
    chk("rst_rvalid", {a_v2, a_v1, a_v0}, 3'b000);
    chk("rst_bus", {a_op, a_adr, a_wren}, '0);
    chk("rst_rdata", a_rdata, 32'h0);
    cyc();
    req1 = 1'b0;
    reset = 1'b0;

    // Single read on port 1.
    cyc();
    req1 = 1'b1;
    @(negedge clk);
    chk("rd_gnt", {a_g2, a_g1, a_g0}, 3'b010);
    chk("rd_op", a_op, 1'b1);
    chk("rd_adr", a_adr, 32'h0000_0010);
    chk("rd_rvalid_T", {a_v2, a_v1, a_v0}, 3'b000);
    chk("rd_rdata_T", a_rdata, 32'h0);
    cyc();
    req1 = 1'b0;
    @(negedge clk);
    chk("rd_idle_bus", {a_op, a_adr, a_di, a_wren}, '0);
    chk("rd_rvalid_T1", {a_v2, a_v1, a_v0}, 3'b010);
    chk("rd_rdata_T1", a_rdata, 32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    chk("rd_rvalid_T2", {a_v2, a_v1, a_v0}, 3'b000);
    chk("rd_rdata_T2", a_rdata, 32'h0);

    // Priority then round-robin (MAX_WAIT 15), starting from reset pointer.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) req0 = 1'b0;
      @(negedge clk);
      chk($sformatf("prio_%0d", i), {a_g2, a_g1, a_g0}, exp_pr[i]);
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;

    // Starvation guard (MAX_WAIT 3): port 1 wins every 4th cycle.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("starve_%0d", i), {b_g2, b_g1, b_g0}, exp_st[i]);
      cyc();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Lock: port 1 is held off for 20 cycles, no bus activity.
    cyc();
    lock = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("lock_a_%0d", i), {a_g2, a_g1, a_g0, a_op, a_adr, a_di, a_wren}, '0);
      chk($sformatf("lock_b_%0d", i), {b_g2, b_g1, b_g0, b_op}, 4'b0000);
      cyc();
    end
    req0 = 1'b1;
    @(negedge clk);
    chk("lock_p0", {b_g2, b_g1, b_g0}, 3'b001);
    cyc();
    req0 = 1'b0; lock = 1'b0;
    @(negedge clk);
    chk("unlock_gnt", {a_g2, a_g1, a_g0}, 3'b010);
    cyc();
    req1 = 1'b0;

    // Write on port 2: fields on bus, never an rvalid.
    cyc();
    req2 = 1'b1; wren2 = 4'b0011; wdata2 = 32'h1234_5678; adr2 = 32'h0001_0010;
    @(negedge clk);
    chk("wr_gnt", {a_g2, a_g1, a_g0}, 3'b100);
    chk("wr_wren", a_wren, 4'b0011);
    chk("wr_di", a_di, 32'h1234_5678);
    chk("wr_adr", a_adr, 32'h0001_0010);
    cyc();
    req2 = 1'b0; wren2 = 4'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("wr_norv_%0d", i), {a_v2, a_v1, a_v0}, 3'b000);
      cyc();
    end

    // Reset arriving mid-read discards the pending response.
    req1 = 1'b1; adr1 = 32'h0000_0020;
    @(negedge clk);
    chk("rmr_gnt", {a_g2, a_g1, a_g0}, 3'b010);
    #2;
    reset = 1'b1;
    #1;
    chk("rmr_gnt_in_rst", {a_g2, a_g1, a_g0}, 3'b000);
    req1 = 1'b0;
    cyc();
    chk("rmr_rv_in_rst", {a_v2, a_v1, a_v0}, 3'b000);
    reset = 1'b0;
    @(negedge clk);
    chk("rmr_outs", {a_g2, a_g1, a_g0, a_v2, a_v1, a_v0, a_op, a_rdata, a_wren}, '0);
    chk("rmr_bus", {a_adr, a_di}, '0);
    cyc();
    req1 = 1'b1; req2 = 1'b1;
    @(negedge clk);
    chk("rmr_rr1", {a_g2, a_g1, a_g0}, 3'b010);
    chk("rmr_rv_none", {a_v2, a_v1, a_v0}, 3'b000);
    cyc();
    @(negedge clk);
    chk("rmr_rr2", {a_g2, a_g1, a_g0}, 3'b100);
    chk("rmr_rv_b2b", {a_v2, a_v1, a_v0}, 3'b010);
    cyc();
    req1 = 1'b0; req2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against the run not terminating.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single SoC memory bus (RAM 0x00000, MMIO 0x10000, ROM 0x20000 windows) between three masters: port 0 = debug unit (dbgu32), port 1 = CPU data port, port 2 = secondary master (DMA/peripheral engine).
- Replaces the ad-hoc dbg/cpu mux with a one-transaction-per-cycle request/grant scheme.
- Routes the one-cycle-latency read data back to the owning master.
- Includes a starvation guard so port 0 cannot lock out ports 1 and 2 indefinitely.

Parameters:
- ADR_W, 32, address width of all ports and of the bus.
- DATA_W, 32, data width; wren is DATA_W/8 bits.
- MAX_WAIT, 15, number of consecutive denied cycles after which port 1/2 overrides port 0 priority (range 1..255).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- lock  input  1  port 0 exclusive-bus request; disables ports 1 and 2 and the starvation override.
- req0/req1/req2  input  1 each  transaction request.
- adr0/adr1/adr2  input  ADR_W each  byte address.
- wdata0/wdata1/wdata2  input  DATA_W each  write data.
- wren0/wren1/wren2  input  DATA_W/8 each  byte enables; all-zero means read.
- gnt0/gnt1/gnt2  output  1 each  combinational grant; transaction accepted this cycle.
- rvalid0/rvalid1/rvalid2  output  1 each  read data valid for that port.
- rdata  output  DATA_W  read data, shared by all ports; qualify with rvalid.
- bus_op  output  1  bus cycle active (memory/MMIO chip-select qualifier).
- bus_adr  output  ADR_W  granted address.
- bus_di  output  DATA_W  granted write data.
- bus_wren  output  DATA_W/8  granted byte enables.
- bus_do  input  DATA_W  OR-combined memory/MMIO read data, valid one cycle after bus_op.

Behaviour:
- Reset values: gnt* = 0, rvalid* = 0, bus_op = 0, bus_adr/bus_di/bus_wren = 0, rr_ptr = port 1, wait counters = 0, pending-response register cleared.
- While reset is high, all gnt* are forced to 0.
- Handshake:
  - A master raises req with stable adr/wdata/wren and holds them until it samples gnt = 1 on a rising edge.
  - Dropping req before gnt is legal and causes no bus cycle.
  - At most one gnt is high per cycle.
- Bus drive:
  - In the grant cycle T, bus_op = 1 and bus_adr/bus_di/bus_wren carry the winner's fields.
  - When no grant, all bus_* outputs are 0 (required by the OR-combined read bus).
- Read response:
  - If the granted transaction at T had wren == 0, then at T+1 rvalid of that port = 1 for exactly one cycle and rdata = bus_do.
  - Writes produce no rvalid.
- rdata:
  - Equals bus_do only in a cycle where some rvalid is high; otherwise 0.
  - A new grant in T+1 is allowed (back-to-back, fully pipelined); one transaction per cycle maximum.
- Priority, evaluated each cycle:
  1. lock = 1: only port 0 may be granted; counters hold.
  2. Starved port: a port 1/2 with wait counter == MAX_WAIT. If both are starved, rr_ptr chooses between them.
  3. Port 0.
  4. Ports 1/2 round-robin: rr_ptr names the preferred port. After a grant to port 1, rr_ptr = port 2; after a grant to port 2, rr_ptr = port 1. Grants to port 0 leave rr_ptr unchanged.
- Wait counters (ports 1, 2 only):
  - Increment each cycle with req & ~gnt & ~lock, saturating at MAX_WAIT.
  - Cleared on grant or when req = 0.
- Async reset mid-transaction: the pending response is discarded; no rvalid after reset release for a transaction granted before reset.
- Simultaneous rvalid and new grant to the same port in one cycle is legal and must be handled.

Test Plan:
- Single read:
  - Stimulus: req1 with adr1 = 0x00010, wren1 = 0; memory returns 0xDEADBEEF.
  - Response: gnt1 at T; bus_adr = 0x00010 and bus_op = 1 at T; rvalid1 = 1 with rdata = 0xDEADBEEF at T+1 only.
- Priority and round-robin:
  - Stimulus: req0/1/2 all high for 4 cycles with MAX_WAIT = 15.
  - Response: grants 0,0,0,0. Then drop req0: grants 1,2,1,2.
- Starvation:
  - Stimulus: req0 and req1 held continuously, MAX_WAIT = 3.
  - Response: gnt0 for 3 cycles, gnt1 on cycle 4, then gnt0 resumes with counter 0.
- Lock:
  - Stimulus: lock = 1, req0 = 0, req1 = 1 for 20 cycles.
  - Response: no grant at all, bus_op = 0 and bus_* = 0. Release lock: gnt1 the next cycle.
- Write:
  - Stimulus: wren2 = 4'b0011, wdata2 = 0x12345678, adr2 = 0x10010.
  - Response: bus_wren = 0011 and bus_di = 0x12345678 in the grant cycle; no rvalid2 ever.
- Reset mid-read:
  - Stimulus: grant read on port 1 at T; assert reset asynchronously between T and T+1.
  - Response: rvalid1 stays 0; after release all outputs are 0 and rr_ptr = port 1.
